bombe_crib_search: RTL and testbench

- Parametrised successor to the three-letter bombe datapath and control.
- Holds a programmable crib of CRIB_LEN plaintext/ciphertext letter pairs and sweeps the shift key 0..25, evaluating one key per step_en tick.
- Reports each matching key and can resume the sweep to find later matches.
- Sits between the keyboard/loader front end and the result display; step_en is driven by the existing quarter-second rate divider, or tied high for full-speed search.

---
 rtl/bombe_crib_search.sv | 207 ++++++++++++++++++++
 tb/tb_bombe_crib_search.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bombe_crib_search.sv
// bombe_crib_search
//   Crib-driven shift-key search. A crib of CRIB_LEN ciphertext/plaintext
//   letter pairs is loaded through the write port. start then sweeps the key
//   k = 0..25, testing one key on each cycle that has step_en high. Position i
//   is decrypted with shift (k + i*STEP) mod 26. A plaintext '?' matches any
//   letter. Each matching key is reported in FOUND, and cont resumes the sweep.
//
// Optional feature: define BOMBE_MATCH_COUNT_EN to add the match_count output.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_idx/wr_char  crib write (wr_sel: 0 cipher, 1 plain)
//   start, cont, step_en     sweep control (start > cont > step_en)
//   busy/found/done          registered state flags (SEARCH/FOUND/EXHAUSTED)
//   bad_char                 sticky invalid-character flag
//   key_out                  matching key, 8'hFF on exhaustion
//   match_count              (BOMBE_MATCH_COUNT_EN) matches in this sweep, max 26
module bombe_crib_search #(
    parameter int unsigned CRIB_LEN = 3,
    parameter int unsigned STEP     = 1,
    parameter int unsigned IDX_W    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_char,
    input  logic             start,
    input  logic             cont,
    input  logic             step_en,
    output logic             busy,
    output logic             found,
    output logic             done,
    output logic             bad_char,
    output logic [7:0]       key_out
`ifdef BOMBE_MATCH_COUNT_EN
    ,
    output logic [4:0]       match_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    k_q, k_d;
    logic [7:0]    key_q, key_d;
    logic          bad_q, bad_d;
    logic          busy_q, found_q, done_q;
    logic [7:0]    cipher_q [CRIB_LEN];
    logic [7:0]    plain_q  [CRIB_LEN];
    logic [CRIB_LEN-1:0] pos_hit;
    logic [CRIB_LEN-1:0] slot_ok;
    logic          hit;
    logic          all_valid;
    logic          wr_ok;
    logic          wr_bad;

`ifdef BOMBE_MATCH_COUNT_EN
    logic [4:0]    cnt_q, cnt_d;
`endif

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    // Per-position decrypt and compare, all in 5-bit mod-26 arithmetic.
    for (genvar gi = 0; gi < CRIB_LEN; gi++) begin : g_pos
        localparam logic [4:0] OFFS = 5'((gi * STEP) % 26);
        logic [5:0] shift_sum;
        logic [4:0] shift;
        logic [4:0] cval;
        logic [4:0] dval;
        logic [7:0] dec;

        assign shift_sum = {1'b0, k_q} + {1'b0, OFFS};
        assign shift     = (shift_sum >= 6'd26) ? 5'(shift_sum - 6'd26) : shift_sum[4:0];
        assign cval      = 5'(cipher_q[gi] - 8'h41);
        assign dval      = (cval >= shift) ? (cval - shift)
                                           : 5'(6'(cval) + 6'd26 - 6'(shift));
        assign dec       = 8'h41 + {3'b000, dval};
        assign pos_hit[gi] = (plain_q[gi] == 8'h3F) || (dec == plain_q[gi]);
        assign slot_ok[gi] = is_upper(cipher_q[gi]) &&
                             (is_upper(plain_q[gi]) || (plain_q[gi] == 8'h3F));
    end

    assign hit       = &pos_hit;
    assign all_valid = &slot_ok;
    assign wr_ok     = wr_en && (state_q != S_SEARCH) && (32'(wr_idx) < CRIB_LEN);
    assign wr_bad    = wr_sel ? !(is_upper(wr_char) || (wr_char == 8'h3F))
                              : !is_upper(wr_char);

    // Crib storage. A start in the same cycle validates the pre-write contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < CRIB_LEN; i++) begin
                cipher_q[i] <= '0;
                plain_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < CRIB_LEN; i++) begin
                if (32'(wr_idx) == i) begin
                    if (wr_sel) plain_q[i]  <= wr_char;
                    else        cipher_q[i] <= wr_char;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        key_d   = key_q;
        bad_d   = bad_q;
`ifdef BOMBE_MATCH_COUNT_EN
        cnt_d   = cnt_q;
`endif
        if (start) begin
            if (all_valid) begin
                state_d = S_SEARCH;
                k_d     = '0;
                bad_d   = 1'b0;
`ifdef BOMBE_MATCH_COUNT_EN
                cnt_d   = '0;
`endif
            end else begin
                state_d = S_EXHAUSTED;
                key_d   = 8'hFF;
            end
        end else begin
            case (state_q)
                S_SEARCH: begin
                    if (step_en) begin
                        if (hit) begin
                            state_d = S_FOUND;
                            key_d   = {3'b000, k_q};
`ifdef BOMBE_MATCH_COUNT_EN
                            if (cnt_q != 5'd26) cnt_d = cnt_q + 5'd1;
`endif
                        end else if (k_q == 5'd25) begin
                            state_d = S_EXHAUSTED;
                            key_d   = 8'hFF;
                        end else begin
                            k_d = k_q + 5'd1;
                        end
                    end
                end
                S_FOUND: begin
                    if (cont) begin
                        if (k_q == 5'd25) begin
                            state_d = S_EXHAUSTED;
                            key_d   = 8'hFF;
                        end else begin
                            state_d = S_SEARCH;
                            k_d     = k_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // A write landing alongside an accepted start still flags its character.
        if (wr_ok && wr_bad) bad_d = 1'b1;
    end

    // Flags are flopped from the next state so each output is a clean register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            key_q   <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef BOMBE_MATCH_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
            busy_q  <= (state_d == S_SEARCH);
            found_q <= (state_d == S_FOUND);
            done_q  <= (state_d == S_EXHAUSTED);
`ifdef BOMBE_MATCH_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign found    = found_q;
    assign done     = done_q;
    assign bad_char = bad_q;
    assign key_out  = key_q;
`ifdef BOMBE_MATCH_COUNT_EN
    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_bombe_crib_search.sv
module tb_bombe_crib_search;

    localparam int CRIB_LEN = 3;
    localparam int STEP     = 1;
    localparam int IDX_W    = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             wr_en = 1'b0;
    logic             wr_sel = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [7:0]       wr_char = '0;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic             step_en = 1'b0;
    logic             busy, found, done, bad_char;
    logic [7:0]       key_out;
`ifdef BOMBE_MATCH_COUNT_EN
    logic [4:0]       match_count;
`endif

    int checks = 0;
    int failures = 0;

    // Reference crib contents and sweep observations.
    logic [7:0] m_c [CRIB_LEN];
    logic [7:0] m_p [CRIB_LEN];
    int exp_keys[$];
    int obs_keys[$];
    bit obs_done;
    int obs_key;
    int obs_edges;
    int obs_first;

    bombe_crib_search #(
        .CRIB_LEN(CRIB_LEN),
        .STEP    (STEP),
        .IDX_W   (IDX_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_char (wr_char),
        .start   (start),
        .cont    (cont),
        .step_en (step_en),
        .busy    (busy),
        .found   (found),
        .done    (done),
        .bad_char(bad_char),
        .key_out (key_out)
`ifdef BOMBE_MATCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input int idx, input logic [7:0] ch);
        wr_en = 1'b1; wr_sel = sel; wr_idx = IDX_W'(idx); wr_char = ch;
        cyc();
        wr_en = 1'b0;
        if (idx < CRIB_LEN) begin
            if (sel) m_p[idx] = ch;
            else     m_c[idx] = ch;
        end
    endtask

    task automatic load(input string p, input string c);
        for (int i = 0; i < CRIB_LEN; i++) begin
            wr(1'b1, i, p[i]);
            wr(1'b0, i, c[i]);
        end
    endtask

    function automatic bit model_hit(input int k);
        for (int i = 0; i < CRIB_LEN; i++) begin
            int d;
            d = ((int'(m_c[i]) - 65 - k - i * STEP) % 26 + 26) % 26 + 65;
            if (m_p[i] != 8'h3F && int'(m_p[i]) != d) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_keys();
        exp_keys.delete();
        for (int k = 0; k < 26; k++) if (model_hit(k)) exp_keys.push_back(k);
    endtask

    // Start a sweep and follow it to exhaustion, resuming on every match.
    task automatic sweep(input bit rnd);
        bit was_busy;
        obs_keys.delete();
        obs_done = 0; obs_key = -1; obs_edges = 0; obs_first = -1;
        start = 1'b1; step_en = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            was_busy = busy;
            cyc();
            cont = 1'b0;
            if (was_busy && step_en) obs_edges++;
            if (done) begin
                obs_done = 1; obs_key = int'(key_out);
                break;
            end
            if (found) begin
                obs_keys.push_back(int'(key_out));
                if (obs_first < 0) obs_first = obs_edges;
                cont = 1'b1;
            end
        end
        step_en = 1'b0; cont = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if ({busy, found, done, bad_char, key_out} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", {busy, found, done, bad_char, key_out});
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < CRIB_LEN; i++) begin m_c[i] = 8'h00; m_p[i] = 8'h00; end
        cyc();
    endtask

    task automatic test_basic();
        load("ABC", "DFH");
        model_keys();
        sweep(1'b0);
        checks++;
        if (obs_first !== 4) begin
            failures++; $display("FAIL basic_latency got=%0d want=4", obs_first);
        end
        checks++;
        if (obs_keys.size() != 1 || obs_keys[0] != 3) begin
            failures++; $display("FAIL basic_key got_n=%0d want key 3", obs_keys.size());
        end
        checks++;
        if (!obs_done || obs_key != 255) begin
            failures++; $display("FAIL basic_done got=%0d/%0d want=1/255", obs_done, obs_key);
        end
    endtask

    task automatic test_no_hit();
        load("ABC", "AAA");
        model_keys();
        sweep(1'b0);
        checks++;
        if (obs_keys.size() != exp_keys.size()) begin
            failures++; $display("FAIL nohit_found got=%0d want=%0d", obs_keys.size(), exp_keys.size());
        end
        checks++;
        if (obs_edges != 26 || !obs_done || obs_key != 255) begin
            failures++;
            $display("FAIL nohit_exhaust got edges=%0d done=%0d key=%0d want 26/1/255", obs_edges, obs_done, obs_key);
        end
    endtask

    task automatic test_wildcard();
        load("???", "QRS");
        sweep(1'b0);
        checks++;
        if (obs_keys.size() != 26) begin
            failures++; $display("FAIL wild_count got=%0d want=26", obs_keys.size());
        end
        for (int k = 0; k < obs_keys.size() && k < 26; k++) begin
            checks++;
            if (obs_keys[k] != k) begin
                failures++; $display("FAIL wild_order idx=%0d got=%0d want=%0d", k, obs_keys[k], k);
            end
        end
        checks++;
        if (!obs_done || obs_key != 255) begin
            failures++; $display("FAIL wild_done got=%0d/%0d want=1/255", obs_done, obs_key);
        end
`ifdef BOMBE_MATCH_COUNT_EN
        checks++;
        if (match_count !== 5'd26) begin
            failures++; $display("FAIL wild_match_count got=%0d want=26", match_count);
        end
`endif
    endtask

    task automatic test_bad_char();
        load("ABC", "DFH");
        wr(1'b0, 1, 8'h61);
        checks++;
        if (bad_char !== 1'b1) begin
            failures++; $display("FAIL bad_set got=%b want=1", bad_char);
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || key_out !== 8'hFF || found !== 1'b0 || bad_char !== 1'b1) begin
            failures++;
            $display("FAIL bad_start got done=%b key=%h found=%b bad=%b want 1/ff/0/1", done, key_out, found, bad_char);
        end
        wr(1'b0, 1, "F");
        model_keys();
        sweep(1'b0);
        checks++;
        if (bad_char !== 1'b0 || obs_keys.size() != 1 || obs_keys[0] != 3) begin
            failures++; $display("FAIL bad_recover got bad=%b n=%0d want 0 and key 3", bad_char, obs_keys.size());
        end
    endtask

    task automatic test_step_pulsed();
        int pulses = 0;
        bit was_busy;
        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            step_en = (c % 4 == 3);
            was_busy = busy;
            cyc();
            if (step_en && was_busy) pulses++;
            step_en = 1'b0;
            if (found || done) break;
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL pulse_busy cycle=%0d got=%b want=1", c, busy);
            end
        end
        checks++;
        if (pulses != 4 || found !== 1'b1 || key_out !== 8'd3) begin
            failures++; $display("FAIL pulse_key got pulses=%0d found=%b key=%0d want 4/1/3", pulses, found, key_out);
        end
    endtask

    task automatic test_write_guard();
        wr(1'b0, 3, 8'h01);
        checks++;
        if (bad_char !== 1'b0) begin
            failures++; $display("FAIL idx_range got=%b want=0", bad_char);
        end
        start = 1'b1; cyc(); start = 1'b0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = '0; wr_char = 8'h00;
        cyc();
        wr_en = 1'b0;
        checks++;
        if (bad_char !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL busy_write got bad=%b busy=%b want 0/1", bad_char, busy);
        end
        cont = 1'b1; cyc(); cont = 1'b0;
        checks++;
        if (busy !== 1'b1 || found !== 1'b0) begin
            failures++; $display("FAIL cont_search got busy=%b found=%b want 1/0", busy, found);
        end
        model_keys();
        sweep(1'b0);
        checks++;
        if (obs_keys.size() != exp_keys.size() || obs_keys[0] != exp_keys[0]) begin
            failures++; $display("FAIL guard_sweep got n=%0d want=%0d", obs_keys.size(), exp_keys.size());
        end
    endtask

    task automatic test_restart();
        int edges = 0;
        load("ABC", "UWY");
        start = 1'b1; step_en = 1'b1; cyc(); start = 1'b0;
        for (int c = 0; c < 10; c++) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            edges++;
            if (found || done) break;
        end
        step_en = 1'b0;
        checks++;
        if (edges != 21 || found !== 1'b1 || key_out !== 8'd20) begin
            failures++; $display("FAIL restart got edges=%0d found=%b key=%0d want 21/1/20", edges, found, key_out);
        end
    endtask

    task automatic test_start_write_same_cycle();
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = '0; wr_char = 8'h61; start = 1'b1;
        cyc();
        wr_en = 1'b0; start = 1'b0; m_c[0] = 8'h61;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL sw_old_valid got busy=%b want=1", busy);
        end
        step_en = 1'b1;
        for (int c = 0; c < 60 && busy; c++) begin cont = found; cyc(); end
        step_en = 1'b0; cont = 1'b0;
        for (int c = 0; c < 60 && busy; c++) cyc();
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = '0; wr_char = "U"; start = 1'b1;
        cyc();
        wr_en = 1'b0; start = 1'b0; m_c[0] = "U";
        checks++;
        if (done !== 1'b1 || key_out !== 8'hFF) begin
            failures++; $display("FAIL sw_old_invalid got done=%b key=%h want 1/ff", done, key_out);
        end
        cont = 1'b1; cyc(); cont = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL cont_exhausted got done=%b busy=%b want 1/0", done, busy);
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bad_char !== 1'b0) begin
            failures++; $display("FAIL sw_restart got busy=%b bad=%b want 1/0", busy, bad_char);
        end
    endtask

    task automatic test_async_reset();
        step_en = 1'b1;
        for (int c = 0; c < 5; c++) cyc();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, found, done, bad_char, key_out} !== 12'h000) begin
            failures++; $display("FAIL async_reset got=%h want=000", {busy, found, done, bad_char, key_out});
        end
        step_en = 1'b0;
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < CRIB_LEN; i++) begin m_c[i] = 8'h00; m_p[i] = 8'h00; end
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || key_out !== 8'hFF || busy !== 1'b0) begin
            failures++; $display("FAIL crib_cleared got done=%b key=%h busy=%b want 1/ff/0", done, key_out, busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int kr = $urandom_range(0, 25);
            for (int i = 0; i < CRIB_LEN; i++) begin
                logic [7:0] c = 8'(65 + $urandom_range(0, 25));
                logic [7:0] p = 8'(((int'(c) - 65 - kr - i * STEP) % 26 + 26) % 26 + 65);
                if ($urandom_range(0, 3) == 0) p = 8'h3F;
                wr(1'b0, i, c);
                wr(1'b1, i, p);
            end
            model_keys();
            sweep(1'b1);
            checks++;
            if (obs_keys.size() != exp_keys.size()) begin
                failures++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, obs_keys.size(), exp_keys.size());
            end else begin
                for (int j = 0; j < exp_keys.size(); j++) begin
                    checks++;
                    if (obs_keys[j] != exp_keys[j]) begin
                        failures++; $display("FAIL rand_key it=%0d idx=%0d got=%0d want=%0d", it, j, obs_keys[j], exp_keys[j]);
                    end
                end
            end
            checks++;
            if (!obs_done || obs_key != 255) begin
                failures++; $display("FAIL rand_done it=%0d got=%0d/%0d want=1/255", it, obs_done, obs_key);
            end
`ifdef BOMBE_MATCH_COUNT_EN
            checks++;
            if (int'(match_count) != exp_keys.size()) begin
                failures++; $display("FAIL rand_match_count it=%0d got=%0d want=%0d", it, match_count, exp_keys.size());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_hit();
        test_wildcard();
        test_bad_char();
        test_step_pulsed();
        test_write_guard();
        test_restart();
        test_start_write_same_cycle();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
